// File: rtl/stream_source.sv
`default_nettype none
// ============================================================================
// stream_source: reads data_depth words from memory into a downstream FIFO
// Revision: 1.0 - initial release
// ============================================================================
module stream_source #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [7:0]            data_depth,
  output logic                  Read_Mem_o,
  output logic [ADDR_WIDTH-1:0] addr_Mem_o,
  input  logic [DATA_WIDTH-1:0] data_mem_i,
  input  logic                  Full_i,
  output logic                  Write_Enable_o,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy_o,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [7:0]            depth_q;
  logic [7:0]            rd_cnt;
  logic [7:0]            wr_cnt;
  logic [7:0]            wr_cnt_nxt;
  logic                  in_flight;
  logic [DATA_WIDTH-1:0] skid [2];
  logic                  head;
  logic [1:0]            occ;
  logic [1:0]            occ_after_pop;
  logic                  push;
  logic                  pop;
  logic                  rd_ok;
  logic                  start_run;

  always_comb begin
    start_run     = (state == IDLE) && start_i;
    pop           = (occ != 2'd0) && !Full_i;
    push          = in_flight;
    // Crediting this cycle's pop lets a read issue every clock at steady state
    // while occupancy plus in-flight reads still never exceeds two.
    occ_after_pop = occ - {1'b0, pop};
    rd_ok         = (state == FETCH) && (rd_cnt < depth_q) &&
                    ((occ_after_pop + {1'b0, in_flight}) < 2'd2);
    wr_cnt_nxt    = wr_cnt + {7'd0, pop};

    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = (data_depth == 8'd0) ? DONE : FETCH;
      FETCH:   if (rd_cnt == depth_q) state_nxt = DRAIN;
      DRAIN:   if (wr_cnt_nxt == depth_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      depth_q    <= 8'd0;
      rd_cnt     <= 8'd0;
      wr_cnt     <= 8'd0;
      addr_Mem_o <= '0;
      in_flight  <= 1'b0;
      head       <= 1'b0;
      occ        <= 2'd0;
      skid[0]    <= '0;
      skid[1]    <= '0;
    end else begin
      state     <= state_nxt;
      in_flight <= rd_ok;
      if (start_run) begin
        depth_q    <= data_depth;
        rd_cnt     <= 8'd0;
        wr_cnt     <= 8'd0;
        addr_Mem_o <= '0;
      end else begin
        if (rd_ok) begin
          rd_cnt     <= rd_cnt + 8'd1;
          addr_Mem_o <= addr_Mem_o + ADDR_WIDTH'(1);
        end
        wr_cnt <= wr_cnt_nxt;
      end
      // Tail slot is head offset by the pre-pop occupancy.
      if (push) skid[head ^ occ[0]] <= data_mem_i;
      head <= head ^ pop;
      occ  <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign Read_Mem_o     = rd_ok;
  assign Write_Enable_o = pop;
  assign data_out       = pop ? skid[head] : '0;
  assign busy_o         = (state == FETCH) || (state == DRAIN);
  assign done           = (state == DONE);

endmodule
`default_nettype wire
